display_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-digit multiplexed 7-segment display between up to 4 requesters.
- Each requester holds a 16-bit packed BCD value (4 digits).
- The granted requester's value is registered onto `bcd_out`, which feeds the existing multi-digit display driver's `bcd_in`.
- Each grant lasts a minimum dwell time, so a human can read the display before ownership rotates.

---
 rtl/display_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_share_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Purpose: round-robin arbiter that shares one 4-digit 7-segment display between
//   up to 4 requesters. Each grant is held for a minimum dwell of HOLD_CYCLES.
// Latency: req seen in cycle n gives registered grant/bcd_out after edge n+1.
// Backpressure: none. Requests are level-held; the owner keeps the display until
//   it releases or its dwell expires with another requester waiting.
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   req         per-requester request, level-held
//   bcd_in_all  4 x 16-bit packed BCD; requester i owns bits [16*i+15:16*i]
//   grant       one-hot owner, 0 when idle (registered)
//   bcd_out     owner's BCD value or IDLE_PATTERN (registered)
//   active      high while a grant is held (registered, equals |grant)
module display_share_arbiter #(
  parameter int          HOLD_CYCLES  = 100000000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] bcd_in_all,
  output logic [3:0]  grant,
  output logic [15:0] bcd_out,
  output logic        active
);

  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [15:0]   bcd_q,   bcd_d;
  logic          active_q, active_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    last_q,  last_d;

  logic          pick_all_vld, pick_oth_vld;
  logic [1:0]    pick_all_idx, pick_oth_idx;
  logic          hold_done;

  // Search r starting just after 'last', ascending with wrap 3->0.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [15:0] slice(input logic [63:0] all, input logic [1:0] idx);
    return all[16*idx +: 16];
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // 'last' always equals the current owner while in S_GRANT, so the owner
  // index is last_q and the "others" search naturally starts after it.
  assign {pick_all_vld, pick_all_idx} = rr_pick(req, last_q);
  assign {pick_oth_vld, pick_oth_idx} = rr_pick(req & ~onehot(last_q), last_q);
  assign hold_done = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    bcd_d    = bcd_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        grant_d  = 4'b0000;
        bcd_d    = IDLE_PATTERN;
        active_d = 1'b0;
        cnt_d    = '0;
        if (pick_all_vld) begin
          state_d  = S_GRANT;
          grant_d  = onehot(pick_all_idx);
          last_d   = pick_all_idx;
          bcd_d    = slice(bcd_in_all, pick_all_idx);
          active_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (!req[last_q]) begin
          // Release wins over hold expiry; re-arbitrate from IDLE next edge.
          state_d  = S_IDLE;
          grant_d  = 4'b0000;
          bcd_d    = IDLE_PATTERN;
          active_d = 1'b0;
          cnt_d    = '0;
        end else if (hold_done && pick_oth_vld) begin
          grant_d  = onehot(pick_oth_idx);
          last_d   = pick_oth_idx;
          cnt_d    = '0;
          bcd_d    = slice(bcd_in_all, pick_oth_idx);
          active_d = 1'b1;
        end else begin
          // Owner keeps the display; its value is reloaded every edge.
          cnt_d = hold_done ? '0 : cnt_q + 1'b1;
          bcd_d = slice(bcd_in_all, last_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 4'b0000;
      bcd_q    <= IDLE_PATTERN;
      active_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      bcd_q    <= bcd_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign grant   = grant_q;
  assign bcd_out = bcd_q;
  assign active  = active_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Purpose: directed bench for display_share_arbiter with HOLD_CYCLES = 4.
// Latency: outputs observed 1 time unit after each rising edge.
// Backpressure: not applicable; requests are driven as levels.
module tb_display_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] bcd_all;
  logic [3:0]  grant;
  logic [15:0] bcd_out;
  logic        active;

  int tests;
  int fails;
  logic [3:0] req_at_edge;
  logic       mon_en;

  display_share_arbiter #(
    .HOLD_CYCLES (4),
    .IDLE_PATTERN(16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bcd_in_all(bcd_all),
    .grant     (grant),
    .bcd_out   (bcd_out),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [15:0] v);
    bcd_all[16*i +: 16] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Per-cycle invariants.
  always @(posedge clk) req_at_edge = req;

  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (!((grant == 4'b0000) || ($onehot(grant)))) begin
        fails++;
        $display("FAIL inv_onehot: grant=%b", grant);
      end
      tests++;
      if (active !== (|grant)) begin
        fails++;
        $display("FAIL inv_active: active=%b grant=%b", active, grant);
      end
      tests++;
      if ((grant & ~req_at_edge) !== 4'b0000) begin
        fails++;
        $display("FAIL inv_req: grant=%b req_at_edge=%b", grant, req_at_edge);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (grant !== 4'b0000 || bcd_out !== 16'h0000 || active !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: grant=%b bcd=%h active=%b want 0000/0000/0", grant, bcd_out, active);
      end
    end
    reset = 1'b0;
    tick();
    tests++;
    if (grant !== 4'b0001 || bcd_out !== 16'h1111 || active !== 1'b1) begin
      fails++;
      $display("FAIL reset_first: grant=%b bcd=%h active=%b want 0001/1111/1", grant, bcd_out, active);
    end
  endtask

  task automatic test_rotate();
    logic [3:0]  exp_g;
    logic [15:0] exp_b;
    do_reset();
    set_slice(0, 16'h1234);
    set_slice(2, 16'h9876);
    req = 4'b0101;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_g = (i <= 4 || i == 9) ? 4'b0001 : 4'b0100;
      exp_b = (i <= 4 || i == 9) ? 16'h1234 : 16'h9876;
      tests++;
      if (grant !== exp_g || bcd_out !== exp_b) begin
        fails++;
        $display("FAIL rotate[%0d]: grant=%b bcd=%h want %b/%h", i, grant, bcd_out, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_single_live();
    do_reset();
    set_slice(3, 16'h0001);
    req = 4'b1000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++;
      if (grant !== 4'b1000 || bcd_out !== 16'h0001) begin
        fails++;
        $display("FAIL single_pre[%0d]: grant=%b bcd=%h want 1000/0001", i, grant, bcd_out);
      end
    end
    set_slice(3, 16'h0002);
    for (int i = 1; i <= 9; i++) begin
      tick();
      tests++;
      if (grant !== 4'b1000 || bcd_out !== 16'h0002) begin
        fails++;
        $display("FAIL single_post[%0d]: grant=%b bcd=%h want 1000/0002", i, grant, bcd_out);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    set_slice(0, 16'h0420);
    set_slice(1, 16'h5555);
    req = 4'b0011;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0001 || bcd_out !== 16'h0420) begin
      fails++;
      $display("FAIL release_own: grant=%b bcd=%h want 0001/0420", grant, bcd_out);
    end
    req = 4'b0010;
    tick();
    tests++;
    if (grant !== 4'b0000 || bcd_out !== 16'h0000 || active !== 1'b0) begin
      fails++;
      $display("FAIL release_gap: grant=%b bcd=%h active=%b want 0000/0000/0", grant, bcd_out, active);
    end
    tick();
    tests++;
    if (grant !== 4'b0010 || bcd_out !== 16'h5555 || active !== 1'b1) begin
      fails++;
      $display("FAIL release_next: grant=%b bcd=%h active=%b want 0010/5555/1", grant, bcd_out, active);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  exp_g;
    logic [15:0] exp_b;
    do_reset();
    set_slice(0, 16'h0007);
    set_slice(3, 16'h4321);
    req = 4'b1001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_g = (i <= 4 || i == 9) ? 4'b0001 : 4'b1000;
      exp_b = (i <= 4 || i == 9) ? 16'h0007 : 16'h4321;
      tests++;
      if (grant !== exp_g || bcd_out !== exp_b) begin
        fails++;
        $display("FAIL wrap[%0d]: grant=%b bcd=%h want %b/%h", i, grant, bcd_out, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_slice(1, 16'h1111);
    set_slice(2, 16'h2222);
    req = 4'b0100;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0100 || bcd_out !== 16'h2222) begin
      fails++;
      $display("FAIL midrst_own: grant=%b bcd=%h want 0100/2222", grant, bcd_out);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b0000 || bcd_out !== 16'h0000 || active !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: grant=%b bcd=%h active=%b want 0000/0000/0", grant, bcd_out, active);
    end
    reset = 1'b0;
    req   = 4'b0110;
    tick();
    tests++;
    if (grant !== 4'b0010 || bcd_out !== 16'h1111) begin
      fails++;
      $display("FAIL midrst_last: grant=%b bcd=%h want 0010/1111", grant, bcd_out);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    mon_en  = 1'b0;
    reset   = 1'b1;
    req     = 4'b0000;
    bcd_all = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_at_edge = 4'b0000;
    test_reset();
    mon_en = 1'b1;
    test_rotate();
    test_single_live();
    test_release();
    test_wrap();
    test_reset_mid();
    mon_en = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
